// File: rtl/minbd_pkg.sv
// Shared definitions for the MinBD side-buffer controller: default flit width,
// controller state encoding and the occupancy-width helper.
package minbd_pkg;

    localparam int FLIT_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } sidebuf_state_t;

    // Width that can hold every value 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/minbd_sidebuf_fifo.sv
// Side-buffer storage: circular array with head/tail pointers and an entry count.
// Push is accepted when not full, or when full but a pop happens in the same cycle.
module minbd_sidebuf_fifo
    import minbd_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = FLIT_W_DEF,
    parameter int CNT_W  = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    input  logic [FLIT_W-1:0] push_data,
    input  logic              pop_grant,
    output logic [FLIT_W-1:0] head_data,
    output logic              full,
    output logic              not_empty,
    output logic [CNT_W-1:0]  count,
    output logic              push,
    output logic              pop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    assign full      = (count == CNT_W'(DEPTH));
    assign not_empty = (count != '0);
    assign pop       = not_empty && pop_grant;
    assign push      = push_valid && (!full || pop);
    assign head_data = mem[head];

    // Storage is deliberately not reset; head/tail/count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/minbd_sidebuf_ctrl.sv
// MinBD side-buffer controller: FIFO of buffered flits, re-injection requests,
// starvation escalation to forced redirection, and a sticky overflow flag.
module minbd_sidebuf_ctrl
    import minbd_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int FLIT_W    = FLIT_W_DEF,
    parameter int STARVE_TH = 8,
    parameter int CNT_W     = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              buf_in_valid,
    input  logic [FLIT_W-1:0] buf_in_flit,
    output logic              buf_full,
    output logic              reinj_req,
    output logic [FLIT_W-1:0] reinj_flit,
    input  logic              reinj_grant,
    output logic              force_reinj,
    output logic [CNT_W-1:0]  occupancy,
    output logic              overflow,
    output sidebuf_state_t    fsm_state
);

    // Handshake: a flit leaves the buffer on a cycle where reinj_req and
    // reinj_grant are both high; the head advances at that clock edge.

    sidebuf_state_t st, st_next;
    logic [7:0]     sc, sc_next;
    logic [8:0]     sc_p1;
    logic           push, pop, will_empty;

    minbd_sidebuf_fifo #(
        .DEPTH (DEPTH),
        .FLIT_W(FLIT_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_valid(buf_in_valid),
        .push_data (buf_in_flit),
        .pop_grant (reinj_grant),
        .head_data (reinj_flit),
        .full      (buf_full),
        .not_empty (reinj_req),
        .count     (occupancy),
        .push      (push),
        .pop       (pop)
    );

    assign sc_p1       = {1'b0, sc} + 9'd1;
    assign will_empty  = pop && !push && (occupancy == CNT_W'(1));
    assign force_reinj = (st == FORCE);
    assign fsm_state   = st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= IDLE;
            sc       <= '0;
            overflow <= 1'b0;
        end else begin
            st <= st_next;
            sc <= sc_next;
            if (buf_in_valid && buf_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        st_next = st;
        sc_next = sc;
        unique case (st)
            IDLE: begin
                if (push) begin
                    st_next = WAIT;
                end
            end
            WAIT: begin
                if (pop) begin
                    sc_next = '0;
                    if (will_empty) begin
                        st_next = IDLE;
                    end
                end else if (reinj_req) begin
                    // Denied cycle: escalate once this denial makes STARVE_TH in a row.
                    if (sc_p1 >= 9'(STARVE_TH)) begin
                        sc_next = 8'(STARVE_TH);
                        st_next = FORCE;
                    end else begin
                        sc_next = sc_p1[7:0];
                    end
                end
            end
            FORCE: begin
                if (pop) begin
                    sc_next = '0;
                    st_next = will_empty ? IDLE : WAIT;
                end
            end
            default: begin
                st_next = IDLE;
                sc_next = '0;
            end
        endcase
    end

endmodule
